d_sync_counter_param: RTL and testbench
=======================================

Name: d_sync_counter_param

Overview:
- Parametrised synchronous up/down counter; successor to the fixed 4-bit D-flip-flop counter.
- Generalised in width and modulus.
- Adds synchronous clear, parallel load, enable, direction select, wrap-or-saturate mode, terminal-count pulse and sticky overflow/underflow flags.
- Sits as a leaf counter block, driven and monitored through the team's counter interface (q/qbar plus control signals).

Parameters:
- WIDTH, 4, counter width in bits (>=1).
- MODULUS, 16, count range 0..MODULUS-1; legal 2..2**WIDTH; elaboration error otherwise.
- SATURATE, 0, 0 = wrap at terminal value, 1 = hold at terminal value.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of count and flags.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- en  in  1  count enable.
- up_dn  in  1  direction: 0 = up, 1 = down.
- flag_clr  in  1  synchronous clear of ovf/unf only.
- q  out  WIDTH  registered count.
- qbar  out  WIDTH  bitwise complement of q, always ~q.
- tc  out  1  registered terminal-count pulse.
- ovf  out  1  sticky up-direction terminal event.
- unf  out  1  sticky down-direction terminal event.

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous and active-low; asserting it forces the reset values immediately, independent of clk. Deassertion is synchronous to clk, handled externally.
- Reset values: q=0, qbar=all ones, tc=0, ovf=0, unf=0.
- MAX = MODULUS-1.
- Per-edge priority: clr > load > en > hold.
- clr: q<=0, tc<=0, ovf<=0, unf<=0. Overrides flag_clr and all other controls.
- load: q <= load_val if load_val <= MAX, else q <= MAX (clamped). tc<=0. Flags unchanged, except flag_clr still applies.
- en, up_dn=0:
  - q<MAX: q<=q+1.
  - q==MAX, wrap mode: q<=0, tc<=1, ovf<=1.
  - q==MAX, saturate mode: q stays MAX, tc<=1, ovf<=1.
- en, up_dn=1:
  - q>0: q<=q-1.
  - q==0, wrap mode: q<=MAX, tc<=1, unf<=1.
  - q==0, saturate mode: q stays 0, tc<=1, unf<=1.
- Hold (no clr/load/en): q unchanged, tc<=0.
- tc is high for exactly one cycle per terminal event and coincides with the post-event q value. Consecutive enabled terminal events in saturate mode keep tc high on every such cycle.
- flag_clr: ovf<=0, unf<=0. If a terminal event occurs in the same cycle, the set wins (flag ends 1).
- Latency: one clk from control sampling to the q update; qbar tracks q combinationally from the register (no extra cycle).
- Arithmetic: done at WIDTH+1 bits internally. q never leaves 0..MAX, and no intermediate value truncates incorrectly when MODULUS==2**WIDTH.
- Direction change mid-count takes effect on the next enabled edge; there is no dead cycle.
- Reset mid-count: immediate return to reset values; counting resumes from 0 on the first enabled edge after release.

Decomposition:
- Shared package cnt_pkg:
  - typedef enum logic {DIR_UP=0, DIR_DOWN=1} cnt_dir_e.
  - localparam-style helper function clamp_load(val, max).
  - Pure function next_count(q, dir, max, saturate) returning the next value plus a terminal-event bit.
- Single module; no sub-module is warranted.
- The counter interface is extended with WIDTH parameterisation, the new control and status signals, and driver/monitor modports.

Test Plan (WIDTH=4, MODULUS=10, SATURATE=0 unless stated):
1. Reset then en=1, up_dn=0 for 12 cycles -> q=1..9,0,1,2; qbar=~q every cycle; tc and ovf rise on the cycle q shows 0; tc=0 the next cycle; ovf stays 1.
2. load=1 with load_val=7, then en=1, up_dn=1 for 9 cycles -> q=7,6,...,0,9; tc and unf set on q=9; load_val=14 -> q=9 (clamped).
3. SATURATE=1, q=8, en=1 up for 3 cycles -> q=9,9,9; tc=0,1,1; ovf=1. Then down with q=0 for 2 cycles -> q stays 0; tc=1 on both cycles; unf=1.
4. Same cycle: clr=1, load=1 (load_val=5), en=1 -> q=0, flags=0. Then load=1 and en=1 with load_val=5 -> q=5 (load beats en).
5. At q=9 going up, flag_clr=1 with ovf=1 -> q=0, tc=1, ovf=1 (set wins). Next cycle flag_clr=1 only -> ovf=0, unf=0.
6. rst_n pulsed low mid-cycle at q=6 without a clk edge -> q=0, qbar=4'hF, tc/ovf/unf=0 immediately. WIDTH=3, MODULUS=8 run of 9 up steps -> q wraps 7->0 correctly.

Source files
------------

// File: rtl/cnt_pkg.sv
// ---------------------------------------------------------------------------
// cnt_pkg
//   Shared types and pure helpers for the parametrised up/down counter family.
//   All count arithmetic is carried out on a fixed internal width (CNT_AW)
//   wide enough for any legal counter up to 32 bits. The extra top bit gives
//   headroom, so that MODULUS == 2**WIDTH never truncates an intermediate
//   value.
//
//   Contents:
//     cnt_dir_e   - count direction (DIR_UP / DIR_DOWN)
//     cnt_val_t   - internal arithmetic word
//     cnt_next_t  - next count value plus terminal-event bit
//     clamp_load  - limit a parallel-load value to the terminal value
//     next_count  - one enabled count step, wrap or saturate
// ---------------------------------------------------------------------------
package cnt_pkg;

  // Internal arithmetic width: the widest supported counter (32) plus one.
  localparam int CNT_AW = 33;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

  typedef logic [CNT_AW-1:0] cnt_val_t;

  typedef struct packed {
    cnt_val_t value;  // count after the step
    logic     term;   // step started on the terminal value for its direction
  } cnt_next_t;

  // Values above the terminal count are clamped to it rather than wrapped.
  function automatic cnt_val_t clamp_load(cnt_val_t val, cnt_val_t max);
    return (val > max) ? max : val;
  endfunction

  // One enabled count step. Counting up from max, or down from zero, is a
  // terminal event. In wrap mode the count jumps to the opposite end. In
  // saturate mode it stays where it is.
  function automatic cnt_next_t next_count(cnt_val_t q, cnt_dir_e dir,
                                           cnt_val_t max, logic saturate);
    cnt_next_t r;
    r.value = q;
    r.term  = 1'b0;
    if (dir == DIR_UP) begin
      if (q >= max) begin
        r.term  = 1'b1;
        r.value = saturate ? max : '0;
      end else begin
        r.value = q + cnt_val_t'(1);
      end
    end else begin
      if (q == '0) begin
        r.term  = 1'b1;
        r.value = saturate ? '0 : max;
      end else begin
        r.value = q - cnt_val_t'(1);
      end
    end
    return r;
  endfunction

endpackage : cnt_pkg

// File: rtl/cnt_if.sv
// ---------------------------------------------------------------------------
// cnt_if
//   Counter interface bundle. It carries the control inputs and status
//   outputs of a d_sync_counter_param instance between a driver and any
//   number of passive monitors.
//
//   Parameters:
//     WIDTH     - count width in bits
//   Ports:
//     clk       - counter clock
//     rst_n     - asynchronous active-low reset
//   Signals:
//     clr, load, load_val, en, up_dn, flag_clr  (driver -> counter)
//     q, qbar, tc, ovf, unf                     (counter -> driver/monitor)
//   Modports:
//     driver    - drives controls, observes status
//     counter   - the counter side (controls in, status out)
//     monitor   - observes everything, drives nothing
// ---------------------------------------------------------------------------
interface cnt_if #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst_n
);

  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up_dn;
  logic             flag_clr;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             ovf;
  logic             unf;

  modport driver (
    input  clk, rst_n,
    output clr, load, load_val, en, up_dn, flag_clr,
    input  q, qbar, tc, ovf, unf
  );

  modport counter (
    input  clk, rst_n,
    input  clr, load, load_val, en, up_dn, flag_clr,
    output q, qbar, tc, ovf, unf
  );

  modport monitor (
    input clk, rst_n,
    input clr, load, load_val, en, up_dn, flag_clr,
    input q, qbar, tc, ovf, unf
  );

endinterface : cnt_if

// File: rtl/d_sync_counter_param.sv
// ---------------------------------------------------------------------------
// d_sync_counter_param
//   Parametrised synchronous up/down counter with synchronous clear, parallel
//   load (clamped to the terminal value), count enable, direction select and
//   wrap-or-saturate behaviour. The terminal-count pulse is registered, and
//   the overflow and underflow flags are sticky.
//
//   Parameters:
//     WIDTH     - counter width in bits (1..32)
//     MODULUS   - count range 0..MODULUS-1 (2..2**WIDTH)
//     SATURATE  - 0: wrap at the terminal value, 1: hold at the terminal value
//   Ports:
//     clk       in   rising-edge clock
//     rst_n     in   asynchronous active-low reset
//     clr       in   synchronous clear of the count and all flags
//     load      in   synchronous parallel load of load_val
//     load_val  in   value to load (clamped to MODULUS-1)
//     en        in   count enable
//     up_dn     in   direction: 0 = up, 1 = down
//     flag_clr  in   synchronous clear of ovf/unf (a same-cycle set wins)
//     q         out  registered count
//     qbar      out  bitwise complement of q
//     tc        out  one-cycle terminal-count pulse, aligned with the new q
//     ovf       out  sticky: an up-count terminal event has occurred
//     unf       out  sticky: a down-count terminal event has occurred
// ---------------------------------------------------------------------------
module d_sync_counter_param
  import cnt_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  // -------------------------------------------------------------------------
  // Parameter legality
  // -------------------------------------------------------------------------
  if (WIDTH < 1 || WIDTH > CNT_AW - 1 ||
      MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_param_err
    $error("d_sync_counter_param: illegal WIDTH/MODULUS combination");
  end

  // Terminal value in the internal arithmetic width.
  localparam cnt_val_t MAX_EXT = cnt_val_t'(MODULUS - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_tc_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;

  cnt_dir_e         w_dir;
  cnt_val_t         w_q_ext;
  cnt_val_t         w_load_ext;
  cnt_val_t         w_load_clamped;
  cnt_next_t        w_step;

  // Both helpers return results in 0..MAX, so the bits above WIDTH are
  // always zero. They are folded into a deliberately unused net.
  logic             w_unused_hi;

  assign w_dir          = cnt_dir_e'(up_dn);
  assign w_q_ext        = cnt_val_t'(r_q);
  assign w_load_ext     = cnt_val_t'(load_val);
  assign w_load_clamped = clamp_load(w_load_ext, MAX_EXT);
  assign w_step         = next_count(w_q_ext, w_dir, MAX_EXT, SATURATE);
  assign w_unused_hi    = ^{w_load_clamped[CNT_AW-1:WIDTH],
                            w_step.value[CNT_AW-1:WIDTH]};

  // -------------------------------------------------------------------------
  // Next-state logic. Priority: clr > load > en > hold.
  // -------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_q_nxt   = r_q;
    w_tc_nxt  = 1'b0;
    // A flag clear is applied first, so a terminal event in the same cycle
    // sets the flag again further down and wins.
    w_ovf_nxt = r_ovf & ~flag_clr;
    w_unf_nxt = r_unf & ~flag_clr;

    if (clr) begin
      w_q_nxt   = '0;
      w_ovf_nxt = 1'b0;
      w_unf_nxt = 1'b0;
    end else if (load) begin
      w_q_nxt = w_load_clamped[WIDTH-1:0];
    end else if (en) begin
      w_q_nxt  = w_step.value[WIDTH-1:0];
      w_tc_nxt = w_step.term;
      if (w_step.term) begin
        if (w_dir == DIR_UP) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_unf_nxt = 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_tc  <= w_tc_nxt;
      r_ovf <= w_ovf_nxt;
      r_unf <= w_unf_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign q    = r_q;
  assign qbar = ~r_q;
  assign tc   = r_tc;
  assign ovf  = r_ovf;
  assign unf  = r_unf;

endmodule : d_sync_counter_param

// File: tb/tb_d_sync_counter_param.sv
// ---------------------------------------------------------------------------
// tb_d_sync_counter_param
//   Three counter instances share one control stream:
//     inst 0: WIDTH=4 MODULUS=10 wrap
//     inst 1: WIDTH=4 MODULUS=10 saturate
//     inst 2: WIDTH=3 MODULUS=8  wrap (fed load_val[2:0])
//   A behavioural model written with modular arithmetic tracks each instance.
//   The model is compared after every edge. A vector table and some
//   hand-written sequences also carry literal expectations.
// ---------------------------------------------------------------------------
module tb_d_sync_counter_param;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       up_dn;
  logic       flag_clr;

  logic [3:0] q0, qb0, q1, qb1;
  logic [2:0] q2, qb2;
  logic       tc0, ovf0, unf0, tc1, ovf1, unf1, tc2, ovf2, unf2;

  int n_checks = 0;
  int n_errors = 0;

  d_sync_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .flag_clr(flag_clr),
    .q(q0), .qbar(qb0), .tc(tc0), .ovf(ovf0), .unf(unf0));

  d_sync_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .flag_clr(flag_clr),
    .q(q1), .qbar(qb1), .tc(tc1), .ovf(ovf1), .unf(unf1));

  d_sync_counter_param #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u_w3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val[2:0]),
    .en(en), .up_dn(up_dn), .flag_clr(flag_clr),
    .q(q2), .qbar(qb2), .tc(tc2), .ovf(ovf2), .unf(unf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  int m_mod  [3] = '{10, 10, 8};
  int m_mask [3] = '{15, 15, 7};
  bit m_sat  [3] = '{1'b0, 1'b1, 1'b0};
  int m_q    [3];
  bit m_tc   [3];
  bit m_ovf  [3];
  bit m_unf  [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_q[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
    end
  endtask

  task automatic model_edge(input bit c, input bit l, input int lv,
                            input bit e, input bit d, input bit fc);
    for (int k = 0; k < 3; k++) begin
      int  top;
      int  v;
      bit  hit;
      top = m_mod[k] - 1;
      v   = lv & m_mask[k];
      if (c) begin
        m_q[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end else begin
        if (fc) begin m_ovf[k] = 0; m_unf[k] = 0; end
        if (l) begin
          m_q[k]  = (v > top) ? top : v;
          m_tc[k] = 0;
        end else if (e) begin
          hit = d ? (m_q[k] == 0) : (m_q[k] == top);
          if (hit && m_sat[k]) m_q[k] = m_q[k];
          else if (!d)         m_q[k] = (m_q[k] + 1) % m_mod[k];
          else                 m_q[k] = (m_q[k] + m_mod[k] - 1) % m_mod[k];
          m_tc[k] = hit;
          if (hit && !d) m_ovf[k] = 1;
          if (hit &&  d) m_unf[k] = 1;
        end else begin
          m_tc[k] = 0;
        end
      end
    end
  endtask

  // ---------------- DUT accessors ----------------
  function automatic logic [31:0] dut_q(int k);
    case (k)
      0:       return 32'(q0);
      1:       return 32'(q1);
      default: return 32'(q2);
    endcase
  endfunction

  function automatic logic [31:0] dut_qb(int k);
    case (k)
      0:       return 32'(qb0);
      1:       return 32'(qb1);
      default: return 32'(qb2);
    endcase
  endfunction

  function automatic logic [2:0] dut_st(int k);  // {tc, ovf, unf}
    case (k)
      0:       return {tc0, ovf0, unf0};
      1:       return {tc1, ovf1, unf1};
      default: return {tc2, ovf2, unf2};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < 3; k++) begin
      logic [2:0] st;
      st = dut_st(k);
      check($sformatf("%s.i%0d.q", tag, k),    dut_q(k),  32'(m_q[k]));
      check($sformatf("%s.i%0d.qbar", tag, k), dut_qb(k), 32'((~m_q[k]) & m_mask[k]));
      check($sformatf("%s.i%0d.tc", tag, k),   32'(st[2]), 32'(m_tc[k]));
      check($sformatf("%s.i%0d.ovf", tag, k),  32'(st[1]), 32'(m_ovf[k]));
      check($sformatf("%s.i%0d.unf", tag, k),  32'(st[0]), 32'(m_unf[k]));
    end
  endtask

  // Apply one set of controls, take one rising edge, sample 1 ns later.
  task automatic step(input string tag, input bit c, input bit l, input int lv,
                      input bit e, input bit d, input bit fc);
    clr = c; load = l; load_val = 4'(lv); en = e; up_dn = d; flag_clr = fc;
    @(posedge clk);
    model_edge(c, l, lv, e, d, fc);
    #1;
    check_model(tag);
  endtask

  // ---------------- directed vector table (instance 0 expectations) -------
  typedef struct {
    bit clr; bit load; int lv; bit en; bit dn; bit fc;
    int eq;  bit etc;  bit eovf; bit eunf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit c, input bit l, input int lv, input bit e, input bit d,
                     input bit fc, input int eq, input bit etc, input bit eo, input bit eu);
    vec_t v;
    v.clr = c; v.load = l; v.lv = lv; v.en = e; v.dn = d; v.fc = fc;
    v.eq = eq; v.etc = etc; v.eovf = eo; v.eunf = eu;
    vecs.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; clr = 0; load = 0; load_val = 0; en = 0; up_dn = 0; flag_clr = 0;
    model_reset();

    // Plan 1: count up 12 from reset: 1..9,0,1,2; wrap at the 10th step
    for (int i = 1; i <= 12; i++) add(0, 0, 0, 1, 0, 0, i % 10, i == 10, i >= 10, 0);
    add(0, 0, 0, 0, 0, 0, 2, 0, 1, 0);                 // hold: tc low
    // Plan 2: load 7 then count down through zero to 9
    add(0, 1, 7, 0, 0, 0, 7, 0, 1, 0);
    for (int i = 1; i <= 8; i++) add(0, 0, 0, 1, 1, 0, (i == 8) ? 9 : 7 - i, i == 8, 1, i == 8);
    add(0, 1, 14, 0, 0, 0, 9, 0, 1, 1);                // clamped load
    // Plan 4: clr beats load and en; load beats en
    add(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 5, 1, 0, 0, 5, 0, 0, 0);
    // Direction change without a dead cycle
    add(0, 0, 0, 1, 1, 0, 4, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 5, 0, 0, 0);
    // Plan 5: terminal event together with flag_clr keeps the flag set
    add(0, 1, 9, 0, 0, 0, 9, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Reset state, checked before release
    #12;
    check_model("reset");
    check("reset.qbar_ones", 32'(qb0), 32'hF);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].clr, vecs[i].load, vecs[i].lv,
           vecs[i].en, vecs[i].dn, vecs[i].fc);
      check($sformatf("vec%0d.lit.q", i),   32'(q0),   32'(vecs[i].eq));
      check($sformatf("vec%0d.lit.tc", i),  32'(tc0),  32'(vecs[i].etc));
      check($sformatf("vec%0d.lit.ovf", i), 32'(ovf0), 32'(vecs[i].eovf));
      check($sformatf("vec%0d.lit.unf", i), 32'(unf0), 32'(vecs[i].eunf));
    end

    // Plan 3: saturate instance, up past 9 then down past 0
    step("p3.ld8", 0, 1, 8, 0, 0, 0);
    step("p3.up1", 0, 0, 0, 1, 0, 0);
    check("p3.up1.q", 32'(q1), 9);   check("p3.up1.tc", 32'(tc1), 0);
    step("p3.up2", 0, 0, 0, 1, 0, 0);
    check("p3.up2.q", 32'(q1), 9);   check("p3.up2.tc", 32'(tc1), 1);
    step("p3.up3", 0, 0, 0, 1, 0, 0);
    check("p3.up3.q", 32'(q1), 9);   check("p3.up3.tc", 32'(tc1), 1);
    check("p3.up3.ovf", 32'(ovf1), 1);
    step("p3.ld0", 0, 1, 0, 0, 0, 0);
    step("p3.dn1", 0, 0, 0, 1, 1, 0);
    check("p3.dn1.q", 32'(q1), 0);   check("p3.dn1.tc", 32'(tc1), 1);
    step("p3.dn2", 0, 0, 0, 1, 1, 0);
    check("p3.dn2.q", 32'(q1), 0);   check("p3.dn2.tc", 32'(tc1), 1);
    check("p3.dn2.unf", 32'(unf1), 1);

    // Plan 6: asynchronous reset mid-cycle at q=6
    step("p6.ld6", 0, 1, 6, 0, 0, 0);
    step("p6.up", 0, 0, 0, 1, 0, 0);   // wrap instance 6 -> 7, then back down
    step("p6.dn", 0, 0, 0, 1, 1, 0);
    check("p6.pre.q", 32'(q0), 6);
    en = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("p6.async.q", 32'(q0), 0);
    check("p6.async.qbar", 32'(qb0), 32'hF);
    check("p6.async.flags", 32'({tc0, ovf0, unf0}), 0);
    check_model("p6.async");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step("p6.resume", 0, 0, 0, 1, 0, 0);
    check("p6.resume.q", 32'(q0), 1);

    // WIDTH=3, MODULUS=8: nine up steps from zero wrap 7 -> 0
    step("w3.clr", 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      step($sformatf("w3.up%0d", i), 0, 0, 0, 1, 0, 0);
      check($sformatf("w3.up%0d.q", i),  32'(q2),  32'(i % 8));
      check($sformatf("w3.up%0d.tc", i), 32'(tc2), 32'(i == 8));
    end
    check("w3.ovf", 32'(ovf2), 1);

    // Randomised stream against the model
    for (int i = 0; i < 400; i++) begin
      bit c, l, e, d, fc;
      int lv;
      c  = ($urandom_range(0, 31) == 0);
      l  = ($urandom_range(0, 7) == 0);
      lv = int'($urandom_range(0, 15));
      e  = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 1) == 1);
      fc = ($urandom_range(0, 15) == 0);
      step($sformatf("rnd%0d", i), c, l, lv, e, d, fc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_d_sync_counter_param
